// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, credit-limited request/grant/response fetch,
// 2-entry instruction FIFO toward decode, and branch/jump redirect with response dropping.
//
// state | meaning
// BOOT  | first cycle after reset, no fetch requests issued
// RUN   | normal fetching, requests limited by out_cnt + fifo_cnt < 2
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        branch_i,
  input  logic        jump_i,
  input  logic [31:0] target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        instr_ready_i
);

  typedef enum logic {BOOT, RUN} state_t;

  state_t      state, state_next;
  logic [31:0] pc;
  logic [31:0] target_word;
  logic [1:0]  out_cnt, out_cnt_next;
  logic [1:0]  fifo_cnt;
  logic [1:0]  drop_cnt;

  logic [31:0] pcq [2];
  logic        pcq_wr, pcq_rd;

  logic [31:0] fifo_ins [2];
  logic [31:0] fifo_pc  [2];
  logic        fifo_rd;
  logic        fifo_wr;

  logic redirect, grant, resp, drop_resp, push, pop;

  assign target_word  = target_i & 32'hFFFF_FFFC;
  assign redirect     = branch_i | jump_i;
  assign grant        = imem_req_o & imem_gnt_i;
  assign resp         = imem_rvalid_i;
  assign drop_resp    = resp && (drop_cnt != 2'd0);
  assign push         = resp && !drop_resp && !redirect;
  assign pop          = instr_valid_o && instr_ready_i && !redirect;
  assign out_cnt_next = out_cnt + {1'b0, grant} - {1'b0, resp};
  assign fifo_wr      = fifo_rd ^ fifo_cnt[0];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state <= BOOT;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      BOOT:    state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = BOOT;
    endcase
  end

  // Request depends only on registered state so it never combinationally follows gnt or redirect.
  always_comb begin
    imem_req_o = (state == RUN) && (({1'b0, out_cnt} + {1'b0, fifo_cnt}) < 3'd2);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pc       <= RESET_PC;
      out_cnt  <= 2'd0;
      fifo_cnt <= 2'd0;
      drop_cnt <= 2'd0;
      pcq_wr   <= 1'b0;
      pcq_rd   <= 1'b0;
      fifo_rd  <= 1'b0;
    end else begin
      out_cnt <= out_cnt_next;
      if (grant) pcq_wr <= ~pcq_wr;
      if (resp)  pcq_rd <= ~pcq_rd;

      if (redirect)   pc <= target_word;
      else if (grant) pc <= pc + 32'd4;

      // Everything still in flight after a redirect belongs to the old path.
      if (redirect)       drop_cnt <= out_cnt_next;
      else if (drop_resp) drop_cnt <= drop_cnt - 2'd1;

      if (redirect) begin
        fifo_cnt <= 2'd0;
        fifo_rd  <= 1'b0;
      end else begin
        if (pop) fifo_rd <= ~fifo_rd;
        fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (grant) pcq[pcq_wr] <= pc;
    if (push) begin
      fifo_ins[fifo_wr] <= imem_rdata_i;
      fifo_pc[fifo_wr]  <= pcq[pcq_rd];
    end
  end

  assign imem_addr_o   = pc;
  assign instr_valid_o = (fifo_cnt != 2'd0);
  assign instr_o       = instr_valid_o ? fifo_ins[fifo_rd] : 32'd0;
  assign instr_pc_o    = instr_valid_o ? fifo_pc[fifo_rd]  : 32'd0;

  resp_has_outstanding: assert property (@(posedge clk_i) disable iff (!rst_ni)
    imem_rvalid_i |-> (out_cnt != 2'd0));

endmodule
